// File: rtl/div_pkg.sv
// Shared definitions for the sequential divider.
//   DIV_W   : default divisor/quotient/remainder width
//   state_e : controller states
package div_pkg;
    localparam int DIV_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;
endpackage

// File: rtl/div_step.sv
// One restoring-division step (combinational).
//   rem_i : partial remainder (N+1 bits, always < divisor on entry)
//   bit_i : next dividend bit, shifted in at the LSB
//   dvs_i : divisor
//   rem_o : next partial remainder
//   q_o   : quotient bit produced by this step
module div_step #(
    parameter int N = 16
) (
    input  logic [N:0]   rem_i,
    input  logic         bit_i,
    input  logic [N-1:0] dvs_i,
    output logic [N:0]   rem_o,
    output logic         q_o
);
    logic [N+1:0] sh;
    logic [N+1:0] dv;

    always_comb begin
        sh    = {rem_i, bit_i};
        dv    = {2'b00, dvs_i};
        q_o   = (sh >= dv);
        // After a subtract the result is below the divisor, so N+1 bits hold it.
        rem_o = q_o ? (N+1)'(sh - dv) : sh[N:0];
    end
endmodule

// File: rtl/div_seq.sv
// Sequential unsigned divider, 2N-bit dividend by N-bit divisor,
// one restoring step per cycle with a valid/ready handshake on each side.
//   clk, rst_n           : clock, synchronous active-low reset
//   in_valid/in_ready    : operand handshake (ready only in IDLE)
//   dividend, divisor    : operands
//   out_valid/out_ready  : result handshake (valid only in DONE)
//   quotient, remainder  : result, held until the next result or reset
//   ovf                  : overflow or divide-by-zero, qualified by out_valid
module div_seq
    import div_pkg::*;
#(
    parameter int N = DIV_W
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2*N-1:0] dividend,
    input  logic [N-1:0]   divisor,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N-1:0]   quotient,
    output logic [N-1:0]   remainder,
    output logic           ovf
);
    localparam int CW = $clog2(N + 1);

    state_e        state_q, state_d;
    logic [N:0]    rem_q, rem_d;
    // Low dividend half; bits leave at the MSB while quotient bits enter
    // at the LSB, so after N steps this register holds the quotient.
    logic [N-1:0]  lo_q, lo_d;
    logic [N-1:0]  dvs_q, dvs_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  quo_q, quo_d;
    logic [N-1:0]  rmd_q, rmd_d;
    logic          ovf_q, ovf_d;

    logic [N:0]    step_rem;
    logic          step_q;

    div_step #(.N(N)) u_step (
        .rem_i (rem_q),
        .bit_i (lo_q[N-1]),
        .dvs_i (dvs_q),
        .rem_o (step_rem),
        .q_o   (step_q)
    );

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        lo_d    = lo_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rmd_d   = rmd_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    dvs_d = divisor;
                    // Quotient would not fit in N bits (or divisor is zero).
                    if (divisor == '0 || dividend[2*N-1:N] >= divisor) begin
                        state_d = DONE;
                        quo_d   = '1;
                        rmd_d   = '0;
                        ovf_d   = 1'b1;
                    end else begin
                        state_d = CALC;
                        rem_d   = {1'b0, dividend[2*N-1:N]};
                        lo_d    = dividend[N-1:0];
                        cnt_d   = '0;
                    end
                end
            end
            CALC: begin
                rem_d = step_rem;
                lo_d  = (lo_q << 1) | N'(step_q);
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
                    state_d = DONE;
                    quo_d   = (lo_q << 1) | N'(step_q);
                    rmd_d   = step_rem[N-1:0];
                    ovf_d   = 1'b0;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rem_q   <= '0;
            lo_q    <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
            quo_q   <= '0;
            rmd_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            lo_q    <= lo_d;
            dvs_q   <= dvs_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rmd_q   <= rmd_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign quotient  = quo_q;
    assign remainder = rmd_q;
    assign ovf       = ovf_q;
endmodule

// File: doc/div_seq.md
DIV_SEQ -- requirements
Module: div_seq

Interface
REQ-001 SHALL have parameter N, default 16: divisor, quotient and remainder width; dividend width is 2N.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates occur on its rising edge.
REQ-003 SHALL have port rst_n, input, 1: reset, synchronous and active-low.
REQ-004 SHALL have port in_valid, input, 1: the operand pair is valid.
REQ-005 SHALL have port in_ready, output, 1: the block can accept operands.
REQ-006 SHALL have port dividend, input, 2N: unsigned dividend.
REQ-007 SHALL have port divisor, input, N: unsigned divisor.
REQ-008 SHALL have port out_valid, output, 1: the result is valid.
REQ-009 SHALL have port out_ready, input, 1: downstream accepts the result.
REQ-010 SHALL have port quotient, output, N: unsigned quotient.
REQ-011 SHALL have port remainder, output, N: unsigned remainder.
REQ-012 SHALL have port ovf, output, 1: overflow or divide-by-zero; qualified by out_valid.

Function
REQ-013 SHALL implement a three-state FSM with states IDLE, CALC and DONE.
REQ-014 SHALL drive in_ready=1 only in IDLE and out_valid=1 only in DONE.
REQ-015 SHALL accept operands on an edge where in_valid&&in_ready, registering dividend and divisor; in_valid outside IDLE SHALL be ignored.
REQ-016 SHALL treat divisor==0 or dividend[2N-1:N]>=divisor as overflow: go IDLE->DONE directly, ovf=1, quotient={N{1}}, remainder=0.
REQ-017 SHALL otherwise go IDLE->CALC with partial remainder = dividend[2N-1:N] (N+1 bits) and iteration counter = 0.
REQ-018 SHALL perform one restoring step per CALC cycle, MSB first: shift the partial remainder left, shifting in the next dividend bit; if the result >= divisor, subtract the divisor and set the quotient bit, else keep the result and clear the quotient bit.
REQ-019 SHALL leave CALC after exactly N steps, so out_valid rises N+1 cycles after the accept edge (1 cycle in the overflow case).
REQ-020 SHALL produce results in the non-overflow case that satisfy dividend == quotient*divisor + remainder, with remainder < divisor, and ovf=0.
REQ-021 SHALL hold quotient, remainder and ovf stable in DONE until out_valid&&out_ready, then return to IDLE.
REQ-022 SHALL NOT accept new operands in the cycle the result is consumed; in_ready rises the following cycle.
REQ-023 SHALL NOT change quotient, remainder or ovf in IDLE or CALC; the outputs retain the last result, or reset values.

Reset
REQ-024 SHALL, when rst_n=0 at a rising clk edge, force IDLE, in_ready=1, out_valid=0, quotient=0, remainder=0, ovf=0, counter=0.
REQ-025 SHALL apply reset in any state, including mid-CALC and in DONE with a pending result; the in-flight operation SHALL be discarded with no out_valid pulse.

Structure
REQ-026 SHALL take the state enum (IDLE/CALC/DONE) and the default width constant DIV_W=16 from a shared package div_pkg.
REQ-027 SHALL implement the single restoring step as a combinational sub-module div_step (inputs: partial remainder, incoming bit, divisor; outputs: next remainder, quotient bit), instantiated once.

Verification
REQ-028 SHALL verify basic division: N=16, dividend=1000, divisor=7 -> out_valid 17 cycles after accept, quotient=142, remainder=6, ovf=0.
REQ-029 SHALL verify the maximum non-overflow case: dividend=32'hFFFE_0001, divisor=16'hFFFF -> quotient=16'hFFFF, remainder=0, ovf=0.
REQ-030 SHALL verify overflow: dividend=32'h0001_0000, divisor=1 -> out_valid 1 cycle after accept, ovf=1, quotient=16'hFFFF, remainder=0; divisor=0 with any dividend gives the same.
REQ-031 SHALL verify back-pressure: hold out_ready=0 for 5 cycles in DONE with in_valid=1 and new operands -> outputs stable, in_ready=0, new operands not taken; after release, in_ready=1 one cycle later.
REQ-032 SHALL verify reset mid-operation: assert rst_n=0 on CALC step 8 of 100/3 -> next cycle IDLE with all outputs zero; a subsequent 100/3 -> quotient=33, remainder=1.
REQ-033 SHALL run a randomized 10k-operand check against a reference model using the REQ-020 identity, with random out_ready stalls.
